i_encoder: RTL and testbench
============================

Name: i_encoder

Overview:
- Inverse of the instruction decoder: accepts structured instruction fields over a valid/ready handshake and packs them into the 64-bit instruction format.
- Writes each packed word to instruction memory as DATA_W-bit little-endian beats at an auto-incrementing byte address.
- Sits between the host/program loader and instruction memory. Programs are built in hardware and then read back by the fetch/decode path.

Parameters:
- ADDR_W, 24, instruction-memory byte-address width; wraps modulo 2^ADDR_W.
- DATA_W, 8, memory write-beat width in bits. Legal values: 8, 16, 32, 64. BEATS = 64/DATA_W.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  pulse: load write pointer from base_addr, clear instr_count and err_illegal
- base_addr  in  ADDR_W  start byte address
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept a bundle
- opcode  in  5  instruction opcode
- dest  in  5  destination buffer id
- length_or_cols  in  10  vector length or matrix columns
- rows  in  10  matrix rows
- addr  in  24  DRAM address
- b  in  5  bias buffer id
- x  in  5  input buffer id
- w  in  5  weight buffer id
- mem_valid  out  1  write beat valid
- mem_ready  in  1  memory accepts beat
- mem_addr  out  ADDR_W  beat byte address
- mem_wdata  out  DATA_W  beat data
- busy  out  1  word in flight
- instr_count  out  16  instructions written since reset/start; wraps
- err_illegal  out  1  sticky: illegal opcode seen

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE, in_ready=0 during reset, mem_valid=0, mem_addr=0, mem_wdata=0, busy=0, instr_count=0, err_illegal=0, write pointer=0, beat counter=0.
- Encoding; all unlisted bits are 0:
  - 0x00 NOP: [4:0]=0.
  - 0x01 LOAD_V / 0x03 STORE: [4:0]=opcode, [9:5]=dest, [19:10]=length_or_cols, [63:40]=addr.
  - 0x02 LOAD_M: as LOAD_V plus [29:20]=rows.
  - 0x04 GEMV: [9:5]=dest, [19:10]=cols, [29:20]=rows, [34:30]=b, [39:35]=x, [44:40]=w.
  - 0x05 RELU: [9:5]=dest, [14:10]=x, [29:20]=length_or_cols.
  - Fields not used by an opcode are ignored.
- FSM IDLE:
  - in_ready=1 unless start=1.
  - start has priority: in the start cycle, in_ready=0, pointer<=base_addr, instr_count<=0, err_illegal<=0.
  - Handshake (in_valid & in_ready) with a legal opcode: the encoded word is registered into a 64-bit shift register, beat=0, goto WRITE.
  - Handshake with an illegal opcode (>0x05): bundle consumed, err_illegal<=1, no write, stay IDLE.
- FSM WRITE:
  - busy=1, in_ready=0, mem_valid=1, mem_wdata=shift[DATA_W-1:0], mem_addr=pointer.
  - Outputs are registered: first beat valid the cycle after acceptance (latency 1).
  - On mem_ready: shift right by DATA_W, pointer += DATA_W/8 (mod 2^ADDR_W), beat++.
  - Last beat (beat==BEATS-1) accepted: instr_count++, goto IDLE; mem_valid=0 next cycle.
  - mem_valid/mem_addr/mem_wdata are held stable while mem_ready=0; no beat is dropped or repeated.
  - start is ignored in WRITE.
- Throughput: one instruction per BEATS+1 cycles with mem_ready held at 1.
- Reset mid-WRITE: the partial word is abandoned, all state returns to reset values, and no further beats are issued.

Decomposition:
- Shared package isa_pkg: opcode enum (NOP, LOAD_V, LOAD_M, STORE, GEMV, RELU), field bit-position localparams, INSTR_W=64. The decoder and encoder share this package so the layout is defined once.
- Sub-module i_pack: pure combinational field packer (fields -> 64-bit word, plus illegal flag). The FSM, pointer and counters stay in i_encoder.

Test Plan:
- Reset, start with base_addr=0x000100, LOAD_V dest=3 len=784 addr=0x000100 -> word 0x0001_0000_000C_4061. With DATA_W=8: beats 61 40 0C 00 00 00 01 00 at addresses 0x100..0x107, then instr_count=1.
- GEMV dest=5 cols=784 rows=128 b=2 x=1 w=4 with DATA_W=64 -> single beat 0x0000_0408_880C_40A4 at the pointer, then pointer +8.
- RELU dest=6 x=5 len=128, rows=0x3FF (ignored) -> 0x0000_0000_0800_14C5.
- mem_ready toggled 1,0,0,1,... during a LOAD_M -> outputs held stable while stalled. Exactly BEATS beats with correct data; in_ready stays 0 until after the last beat.
- opcode 0x1F -> err_illegal=1, no mem_valid, instr_count unchanged. A following start clears err_illegal.
- Pointer wrap: base_addr=0xFFFFFC with DATA_W=8 -> beats at 0xFFFFFC..0xFFFFFF, then 0x000000..0x000003. Also: rst_n=0 after the 3rd beat -> mem_valid=0 on the next cycle and all counters are 0.

Source files
------------

// File: rtl/isa_pkg.sv
// Shared instruction-set definitions: opcodes, 64-bit field layout and FSM states.
// Encoder and decoder both import this so the bit layout lives in one place.
package isa_pkg;

  localparam int INSTR_W = 64;

  typedef enum logic [4:0] {
    OP_NOP    = 5'h00,
    OP_LOAD_V = 5'h01,
    OP_LOAD_M = 5'h02,
    OP_STORE  = 5'h03,
    OP_GEMV   = 5'h04,
    OP_RELU   = 5'h05
  } opcode_t;

  // Field least-significant bit positions inside the 64-bit word
  localparam int OPC_LSB    = 0;
  localparam int DEST_LSB   = 5;
  localparam int LEN_LSB    = 10;
  localparam int ROWS_LSB   = 20;
  localparam int B_LSB      = 30;
  localparam int X_LSB      = 35;
  localparam int W_LSB      = 40;
  localparam int ADDR_LSB   = 40;
  localparam int RELU_X_LSB = 10;
  localparam int RELU_L_LSB = 20;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } enc_state_t;

  function automatic logic is_legal(input logic [4:0] op);
    return op <= OP_RELU;
  endfunction

endpackage

// File: rtl/i_pack.sv
// Combinational field packer: structured fields in, 64-bit instruction word out.
// Fields an opcode does not use are dropped; undefined opcodes raise illegal.
module i_pack
  import isa_pkg::*;
(
  input  logic [4:0]         opcode,
  input  logic [4:0]         dest,
  input  logic [9:0]         length_or_cols,
  input  logic [9:0]         rows,
  input  logic [23:0]        addr,
  input  logic [4:0]         b,
  input  logic [4:0]         x,
  input  logic [4:0]         w,
  output logic [INSTR_W-1:0] word,
  output logic               illegal
);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (opcode)
      OP_NOP: word = '0;
      OP_LOAD_V, OP_STORE, OP_LOAD_M: begin
        word[OPC_LSB  +: 5]  = opcode;
        word[DEST_LSB +: 5]  = dest;
        word[LEN_LSB  +: 10] = length_or_cols;
        word[ADDR_LSB +: 24] = addr;
        if (opcode == OP_LOAD_M) word[ROWS_LSB +: 10] = rows;
      end
      OP_GEMV: begin
        word[OPC_LSB  +: 5]  = opcode;
        word[DEST_LSB +: 5]  = dest;
        word[LEN_LSB  +: 10] = length_or_cols;
        word[ROWS_LSB +: 10] = rows;
        word[B_LSB    +: 5]  = b;
        word[X_LSB    +: 5]  = x;
        word[W_LSB    +: 5]  = w;
      end
      OP_RELU: begin
        word[OPC_LSB    +: 5]  = opcode;
        word[DEST_LSB   +: 5]  = dest;
        word[RELU_X_LSB +: 5]  = x;
        word[RELU_L_LSB +: 10] = length_or_cols;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/i_encoder.sv
// Instruction encoder: accepts field bundles, packs them and streams each 64-bit
// word to instruction memory as little-endian DATA_W beats at an auto-incrementing address.
module i_encoder
  import isa_pkg::*;
#(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        opcode,
  input  logic [4:0]        dest,
  input  logic [9:0]        length_or_cols,
  input  logic [9:0]        rows,
  input  logic [23:0]       addr,
  input  logic [4:0]        b,
  input  logic [4:0]        x,
  input  logic [4:0]        w,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic [15:0]       instr_count,
  output logic              err_illegal
);

  localparam int BEATS = INSTR_W / DATA_W;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
  // Input side: in_valid/in_ready. Memory side: mem_valid/mem_ready; mem_valid and
  // its payload stay stable until accepted.

  enc_state_t         state, state_next;
  logic [INSTR_W-1:0] shift;
  logic [ADDR_W-1:0]  ptr;
  logic [3:0]         beat;
  logic [15:0]        count;
  logic               err;
  logic [INSTR_W-1:0] packed_word;
  logic               illegal;
  logic               accept;
  logic               last_beat;

  i_pack u_pack (
    .opcode         (opcode),
    .dest           (dest),
    .length_or_cols (length_or_cols),
    .rows           (rows),
    .addr           (addr),
    .b              (b),
    .x              (x),
    .w              (w),
    .word           (packed_word),
    .illegal        (illegal)
  );

  assign in_ready  = rst_n && (state == ST_IDLE) && !start;
  assign accept    = in_valid && in_ready;
  assign last_beat = (beat == 4'(BEATS - 1));

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (accept && !illegal) state_next = ST_WRITE;
      ST_WRITE: if (mem_ready && last_beat) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      shift <= '0;
      ptr   <= '0;
      beat  <= '0;
      count <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        ST_IDLE: begin
          if (start) begin
            ptr   <= base_addr;
            count <= '0;
            err   <= 1'b0;
          end else if (accept) begin
            if (illegal) begin
              err <= 1'b1;
            end else begin
              shift <= packed_word;
              beat  <= '0;
            end
          end
        end
        ST_WRITE: begin
          if (mem_ready) begin
            shift <= shift >> DATA_W;
            ptr   <= ptr + ADDR_W'(DATA_W / 8);
            beat  <= beat + 4'd1;
            if (last_beat) count <= count + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Memory outputs come straight from registers, so the first beat appears one cycle after acceptance.
  assign mem_valid   = (state == ST_WRITE);
  assign busy        = (state == ST_WRITE);
  assign mem_addr    = ptr;
  assign mem_wdata   = shift[DATA_W-1:0];
  assign instr_count = count;
  assign err_illegal = err;

endmodule

// File: tb/tb_i_encoder.sv
// Bench for i_encoder: a DATA_W=8 and a DATA_W=64 instance, a queue-based beat model
// checked every cycle, plus literal expectations from hand-computed encodings.
module tb_i_encoder;

  logic        clk;
  logic        rst_n;
  logic [1:0]  start;
  logic [1:0]  in_valid;
  logic [1:0]  mem_ready;
  logic [23:0] base_addr;
  logic [4:0]  opcode, dest, b, x, w;
  logic [9:0]  length_or_cols, rows;
  logic [23:0] addr;

  logic [1:0]  in_ready, mem_valid, busy, err_illegal;
  logic [23:0] mem_addr [2];
  logic [15:0] instr_count [2];
  logic [63:0] mem_wdata [2];
  logic [7:0]  wdata8;
  logic [63:0] wdata64;

  int n_assert = 0;
  int n_fail   = 0;
  bit stall_mode = 0;

  assign mem_wdata[0] = {56'b0, wdata8};
  assign mem_wdata[1] = wdata64;

  i_encoder #(.ADDR_W(24), .DATA_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .base_addr(base_addr),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .opcode(opcode), .dest(dest), .length_or_cols(length_or_cols), .rows(rows),
    .addr(addr), .b(b), .x(x), .w(w),
    .mem_valid(mem_valid[0]), .mem_ready(mem_ready[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(wdata8), .busy(busy[0]), .instr_count(instr_count[0]),
    .err_illegal(err_illegal[0])
  );

  i_encoder #(.ADDR_W(24), .DATA_W(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .base_addr(base_addr),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .opcode(opcode), .dest(dest), .length_or_cols(length_or_cols), .rows(rows),
    .addr(addr), .b(b), .x(x), .w(w),
    .mem_valid(mem_valid[1]), .mem_ready(mem_ready[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(wdata64), .busy(busy[1]), .instr_count(instr_count[1]),
    .err_illegal(err_illegal[1])
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Encoding written straight from the field table
  function automatic logic [63:0] enc(input int op, input int d, input int len, input int r,
                                      input int ad, input int bb, input int xx, input int ww);
    logic [63:0] v;
    v = '0;
    case (op)
      1, 3: v = 64'(op) | (64'(d) << 5) | (64'(len) << 10) | (64'(ad) << 40);
      2:    v = 64'(op) | (64'(d) << 5) | (64'(len) << 10) | (64'(r) << 20) | (64'(ad) << 40);
      4:    v = 64'(op) | (64'(d) << 5) | (64'(len) << 10) | (64'(r) << 20)
              | (64'(bb) << 30) | (64'(xx) << 35) | (64'(ww) << 40);
      5:    v = 64'(op) | (64'(d) << 5) | (64'(xx) << 10) | (64'(len) << 20);
      default: v = '0;
    endcase
    return v;
  endfunction

  // mem_ready stimulus: always 1, or the 1,0,0,1 stall pattern
  int phase = 0;
  always @(posedge clk) begin
    #1;
    if (stall_mode) mem_ready = (phase % 4 == 0 || phase % 4 == 3) ? 2'b11 : 2'b00;
    else            mem_ready = 2'b11;
    phase++;
  end

  // Scoreboard / compare process per instance
  for (genvar u = 0; u < 2; u++) begin : g_chk
    localparam int DW = (u == 0) ? 8 : 64;
    logic [87:0] exp_q[$];
    logic [23:0] m_ptr;
    logic [15:0] m_count;
    logic        m_err;
    bit          known = 0;
    bit          just_rst = 0;

    always @(negedge clk) begin
      logic [63:0] wd;
      logic [63:0] mask;
      if (known) begin
        chk("in_ready", 64'(in_ready[u]), 64'(rst_n && exp_q.size() == 0 && !start[u]));
        chk("mem_valid", 64'(mem_valid[u]), 64'(exp_q.size() != 0));
        chk("busy", 64'(busy[u]), 64'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
          chk("mem_addr", 64'(mem_addr[u]), 64'(exp_q[0][87:64]));
          chk("mem_wdata", mem_wdata[u], exp_q[0][63:0]);
        end
        chk("instr_count", 64'(instr_count[u]), 64'(m_count));
        chk("err_illegal", 64'(err_illegal[u]), 64'(m_err));
        if (just_rst) begin
          chk("rst_mem_addr", 64'(mem_addr[u]), 64'h0);
          chk("rst_mem_wdata", mem_wdata[u], 64'h0);
          just_rst = 0;
        end
      end
      if (!rst_n) begin
        known = 1; just_rst = 1;
        exp_q.delete();
        m_ptr = '0; m_count = '0; m_err = 1'b0;
      end else if (known) begin
        if (exp_q.size() != 0) begin
          if (mem_ready[u]) begin
            void'(exp_q.pop_front());
            if (exp_q.size() == 0) m_count = m_count + 16'd1;
          end
        end else if (start[u]) begin
          m_ptr = base_addr; m_count = '0; m_err = 1'b0;
        end else if (in_valid[u]) begin
          if (int'(opcode) > 5) m_err = 1'b1;
          else begin
            wd = enc(int'(opcode), int'(dest), int'(length_or_cols), int'(rows),
                     int'(addr), int'(b), int'(x), int'(w));
            mask = (DW == 64) ? '1 : ((64'd1 << DW) - 64'd1);
            for (int i = 0; i < 64 / DW; i++)
              exp_q.push_back({24'(m_ptr + 24'(i * DW / 8)), (wd >> (i * DW)) & mask});
            m_ptr = m_ptr + 24'd8;
          end
        end
      end
    end
  end

  // driver tasks
  task automatic do_start(input int u, input logic [23:0] base);
    @(posedge clk); #1;
    base_addr = base; start[u] = 1'b1;
    @(posedge clk); #1;
    start[u] = 1'b0;
  endtask

  task automatic send(input int u, input int op, input int d, input int len, input int r,
                      input int ad, input int bb, input int xx, input int ww);
    bit done;
    @(posedge clk); #1;
    opcode = 5'(op); dest = 5'(d); length_or_cols = 10'(len); rows = 10'(r);
    addr = 24'(ad); b = 5'(bb); x = 5'(xx); w = 5'(ww);
    in_valid[u] = 1'b1;
    done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (in_ready[u]) done = 1;
    end
    n_assert++;
    if (!done) begin
      n_fail++;
      $display("FAIL send_timeout: in_ready stayed 0, required 1");
    end
    @(posedge clk); #1;
    in_valid[u] = 1'b0;
  endtask

  task automatic wait_idle(input int u);
    bit done;
    done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (!busy[u]) done = 1;
    end
    n_assert++;
    if (!done) begin
      n_fail++;
      $display("FAIL idle_timeout: busy stayed 1, required 0");
    end
  endtask

  initial begin
    int nb;
    rst_n = 1'b0; start = '0; in_valid = '0; mem_ready = 2'b11; base_addr = '0;
    opcode = '0; dest = '0; length_or_cols = '0; rows = '0; addr = '0; b = '0; x = '0; w = '0;

    // pin the model encodings to hand-computed words
    chk("enc_load_v", enc(1, 3, 784, 0, 'h100, 0, 0, 0), 64'h0001_0000_000C_4061);
    chk("enc_gemv",   enc(4, 5, 784, 128, 0, 2, 1, 4), 64'h0000_0408_880C_40A4);
    chk("enc_relu",   enc(5, 6, 128, 'h3FF, 0, 0, 5, 0), 64'h0000_0000_0800_14C5);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_count", 64'(instr_count[0]), 64'h0);
    chk("reset_valid", 64'(mem_valid[0]), 64'h0);
    chk("reset_ready", 64'(in_ready[0]), 64'h1);

    do_start(0, 24'h000100);
    send(0, 1, 3, 784, 0, 'h100, 0, 0, 0);
    wait_idle(0);
    chk("load_v_count", 64'(instr_count[0]), 64'h1);
    chk("load_v_ptr", 64'(mem_addr[0]), 64'h108);

    send(0, 5, 6, 128, 'h3FF, 0, 0, 5, 0);
    wait_idle(0);

    stall_mode = 1;
    send(0, 2, 7, 300, 200, 'hABCDEF, 0, 0, 0);
    wait_idle(0);
    stall_mode = 0;
    chk("load_m_count", 64'(instr_count[0]), 64'h3);

    send(0, 3, 31, 1023, 1023, 'hFFFFFF, 31, 31, 31);
    wait_idle(0);
    send(0, 0, 9, 9, 9, 9, 9, 9, 9);
    wait_idle(0);

    send(0, 'h1F, 1, 2, 3, 4, 5, 6, 7);
    @(negedge clk);
    chk("illegal_err", 64'(err_illegal[0]), 64'h1);
    chk("illegal_count", 64'(instr_count[0]), 64'h5);
    chk("illegal_no_write", 64'(mem_valid[0]), 64'h0);
    do_start(0, 24'hFFFFFC);
    @(negedge clk);
    chk("start_clears_err", 64'(err_illegal[0]), 64'h0);

    send(0, 1, 2, 5, 0, 'h123456, 0, 0, 0);
    wait_idle(0);
    chk("wrap_ptr", 64'(mem_addr[0]), 64'h000004);

    do_start(1, 24'h000010);
    send(1, 4, 5, 784, 128, 0, 2, 1, 4);
    wait_idle(1);
    chk("gemv_ptr", 64'(mem_addr[1]), 64'h18);
    send(1, 5, 6, 128, 'h3FF, 0, 0, 5, 0);
    wait_idle(1);
    chk("gemv_count", 64'(instr_count[1]), 64'h2);

    // reset after the third accepted beat
    do_start(0, 24'h000020);
    send(0, 1, 1, 1, 0, 'h55AA55, 0, 0, 0);
    nb = 0;
    for (int i = 0; i < 50 && nb < 3; i++) begin
      @(negedge clk);
      if (mem_valid[0] && mem_ready[0]) nb++;
    end
    chk("beats_before_rst", 64'(nb), 64'd3);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_valid", 64'(mem_valid[0]), 64'h0);
    chk("rst_mid_count", 64'(instr_count[0]), 64'h0);
    chk("rst_mid_addr", 64'(mem_addr[0]), 64'h0);
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
